// File: rtl/lutram_march_checker_if.sv
// RAM-side bus between the march checker (master) and a dual-port distributed RAM (slave).
interface lutram_march_checker_if #(
    parameter int unsigned A_WIDTH = 7,
    parameter int unsigned D_WIDTH = 1
);
    logic               ram_we_o;
    logic [A_WIDTH-1:0] ram_a_o;
    logic [A_WIDTH-1:0] ram_dpra_o;
    logic [D_WIDTH-1:0] ram_d_o;
    logic [D_WIDTH-1:0] ram_spo_i;
    logic [D_WIDTH-1:0] ram_dpo_i;

    modport master (
        output ram_we_o, ram_a_o, ram_dpra_o, ram_d_o,
        input  ram_spo_i, ram_dpo_i
    );

    modport slave (
        input  ram_we_o, ram_a_o, ram_dpra_o, ram_d_o,
        output ram_spo_i, ram_dpo_i
    );
endinterface

// File: rtl/lutram_march_checker.sv
// March sequencer for dual-port distributed RAM: clear, verify zero, write pattern, verify pattern.
// Steps are paced by a tick enable; SPO and DPO are both checked on every verify step.
module lutram_march_checker #(
    parameter int unsigned A_WIDTH     = 7,
    parameter int unsigned D_WIDTH     = 1,
    parameter logic [31:0] DIV_COUNT   = 32'd0,
    parameter int unsigned DPRA_OFFSET = 1,
    parameter int unsigned ERR_WIDTH   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [1:0]              mode_i,
    lutram_march_checker_if.master  ram_if,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [ERR_WIDTH-1:0]    err_cnt_o,
    output logic [A_WIDTH-1:0]      fail_addr_o,
    output logic [2:0]              state_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_CHECK0 = 3'd2,
        S_WRITE  = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int unsigned      REP_A     = (D_WIDTH + A_WIDTH - 1) / A_WIDTH;
    localparam int unsigned      REP_C     = (D_WIDTH + 1) / 2;
    localparam logic [A_WIDTH-1:0] DPRA_OFF  = A_WIDTH'(DPRA_OFFSET);
    localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

    state_t               r_state;
    logic [31:0]          r_div;
    logic [A_WIDTH-1:0]   r_addr;
    logic [A_WIDTH-1:0]   r_fail;
    logic [1:0]           r_mode;
    logic [ERR_WIDTH-1:0] r_err;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;

    logic                 w_active;
    logic                 w_tick;
    logic                 w_last;
    logic                 w_check;
    logic [A_WIDTH-1:0]   w_dpra;
    logic [D_WIDTH-1:0]   w_exp_spo;
    logic [D_WIDTH-1:0]   w_exp_dpo;
    logic                 w_spo_bad;
    logic                 w_dpo_bad;
    logic                 w_mismatch;
    logic [ERR_WIDTH-1:0] w_err_next;

    // Bit i of the address-derived patterns is a[i mod A_WIDTH], so replicate and truncate.
    function automatic logic [D_WIDTH-1:0] f_pat(input logic [1:0] m, input logic [A_WIDTH-1:0] a);
        logic [REP_A*A_WIDTH-1:0] rep;
        logic [2*REP_C-1:0]       cb;
        logic [D_WIDTH-1:0]       p;
        rep = {REP_A{a}};
        cb  = {REP_C{2'b10}};
        case (m)
            2'd0:    p = '1;
            2'd1:    p = cb[D_WIDTH-1:0] ^ {D_WIDTH{a[0]}};
            2'd2:    p = rep[D_WIDTH-1:0];
            default: p = ~rep[D_WIDTH-1:0];
        endcase
        return p;
    endfunction

    always_comb begin
        w_active   = (r_state == S_CLEAR) || (r_state == S_CHECK0) ||
                     (r_state == S_WRITE) || (r_state == S_CHECK);
        w_tick     = w_active && (r_div == DIV_COUNT);
        w_last     = w_tick && (r_addr == LAST_ADDR);
        w_check    = (r_state == S_CHECK0) || (r_state == S_CHECK);
        w_dpra     = r_addr + DPRA_OFF;
        w_exp_spo  = (r_state == S_CHECK) ? f_pat(r_mode, r_addr) : '0;
        w_exp_dpo  = (r_state == S_CHECK) ? f_pat(r_mode, w_dpra) : '0;
        w_spo_bad  = w_tick && w_check && (ram_if.ram_spo_i != w_exp_spo);
        w_dpo_bad  = w_tick && w_check && (ram_if.ram_dpo_i != w_exp_dpo);
        w_mismatch = w_spo_bad || w_dpo_bad;
        w_err_next = (w_mismatch && (r_err != '1)) ? r_err + 1'b1 : r_err;
    end

    // Write enable is derived from registered state so reset drops it without waiting for an edge.
    assign ram_if.ram_we_o   = w_tick && ((r_state == S_CLEAR) || (r_state == S_WRITE));
    assign ram_if.ram_a_o    = r_addr;
    assign ram_if.ram_dpra_o = w_dpra;
    assign ram_if.ram_d_o    = (r_state == S_WRITE) ? f_pat(r_mode, r_addr) : '0;

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign err_cnt_o   = r_err;
    assign fail_addr_o = r_fail;
    assign state_o     = r_state;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_addr  <= '0;
            r_fail  <= '0;
            r_mode  <= '0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            if (w_active) begin
                r_div <= w_tick ? '0 : r_div + 32'd1;
                if (w_tick) begin
                    r_addr <= r_addr + 1'b1;
                end
                r_err <= w_err_next;
                if (w_mismatch && (r_err == '0)) begin
                    r_fail <= w_spo_bad ? r_addr : w_dpra;
                end
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_mode  <= mode_i;
                        r_err   <= '0;
                        r_fail  <= '0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_div   <= '0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR:  if (w_last) r_state <= S_CHECK0;
                S_CHECK0: if (w_last) r_state <= S_WRITE;
                S_WRITE:  if (w_last) r_state <= S_CHECK;
                S_CHECK: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
